// File: rtl/lm_sm_pkg.sv
// Shared constants for the LM/SM memory responder: opcodes, FSM encoding and default widths.
package lm_sm_pkg;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_TO_CYC = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/lm_sm_mem_resp.sv
// Per-beat memory sequencer for LM/SM multi-register instructions.
// Optional memory-ack timeout enabled by defining LM_SM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for the next beat
// ISSUE | memory request held until ack (or timeout)
// WB    | one-cycle register write of load data
// DONE  | one-cycle done pulse after the last beat
module lm_sm_mem_resp
  import lm_sm_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TO_CYC = DEF_TO_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_valid,
  output logic              beat_ready,
  input  logic              beat_is_lm,
  input  logic              beat_is_sm,
  input  logic [2:0]        beat_reg,
  input  logic [ADDR_W-1:0] beat_base,
  input  logic [ADDR_W-1:0] beat_off,
  input  logic              beat_last,
  output logic [2:0]        rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [2:0]        rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic              is_sm_q;
  logic              last_q;
  logic [2:0]        reg_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      is_sm_q <= 1'b0;
      last_q  <= 1'b0;
      reg_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Malformed beats (neither or both kinds) are swallowed here.
          if (beat_valid && (beat_is_lm ^ beat_is_sm)) begin
            is_sm_q <= beat_is_sm;
            last_q  <= beat_last;
            reg_q   <= beat_reg;
            addr_q  <= beat_base + beat_off;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_ack) begin
            if (is_sm_q) begin
              state <= last_q ? ST_DONE : ST_IDLE;
            end else begin
              data_q <= mem_rdata;
              state  <= ST_WB;
            end
          end else if (timeout) begin
            state <= ST_IDLE;
          end
        end
        ST_WB:   state <= last_q ? ST_DONE : ST_IDLE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LM_SM_TIMEOUT_EN
  localparam int TMR_W = $clog2(TO_CYC + 1);
  logic [TMR_W-1:0] tmr;

  // Reloaded in IDLE so the final ISSUE cycle before giving up sees zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
    end else if (state == ST_IDLE) begin
      tmr <= TMR_W'(TO_CYC - 1);
    end else if (state == ST_ISSUE && tmr != '0) begin
      tmr <= tmr - 1'b1;
    end
  end

  assign timeout = (state == ST_ISSUE) && (tmr == '0) && !mem_ack;
  assign err     = timeout;
`else
  logic unused_cfg;
  assign unused_cfg = (TO_CYC == 0);
  assign timeout    = 1'b0;
  assign err        = 1'b0;
`endif

  assign beat_ready = (state == ST_IDLE) && !rst;
  assign mem_req    = (state == ST_ISSUE);
  assign mem_we     = (state == ST_ISSUE) && is_sm_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = ((state == ST_ISSUE) && is_sm_q) ? rf_rd_data : '0;
  assign rf_rd_addr = reg_q;
  assign rf_wr_en   = (state == ST_WB);
  assign rf_wr_addr = reg_q;
  assign rf_wr_data = data_q;
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_lm_sm_mem_resp.sv
// Directed self-checking bench for lm_sm_mem_resp (default widths).
module tb_lm_sm_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        beat_valid, beat_ready, beat_is_lm, beat_is_sm, beat_last;
  logic [2:0]  beat_reg;
  logic [15:0] beat_base, beat_off;
  logic [2:0]  rf_rd_addr, rf_wr_addr;
  logic [15:0] rf_rd_data, rf_wr_data;
  logic        rf_wr_en;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        done, err;

  logic [15:0] rf [8];
  int          tests = 0;
  int          fails = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  assign rf_rd_data = rf[rf_rd_addr];

  always @(posedge clk) begin
    if (rf_wr_en === 1'b1) wr_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  lm_sm_mem_resp dut (
    .clk(clk), .rst(rst),
    .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_is_lm(beat_is_lm), .beat_is_sm(beat_is_sm),
    .beat_reg(beat_reg), .beat_base(beat_base), .beat_off(beat_off),
    .beat_last(beat_last),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of cycle 1 after acceptance.
  task automatic send(input logic lm, input logic sm, input logic [2:0] r,
                      input logic [15:0] b, input logic [15:0] o, input logic l);
    chk("beat_ready_before_send", beat_ready, 1);
    beat_valid = 1'b1; beat_is_lm = lm; beat_is_sm = sm;
    beat_reg = r; beat_base = b; beat_off = o; beat_last = l;
    @(posedge clk);
    @(negedge clk);
    beat_valid = 1'b0; beat_is_lm = 1'b0; beat_is_sm = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    rf[5] = 16'h1234;
    rst = 1'b1; beat_valid = 0; beat_is_lm = 0; beat_is_sm = 0; beat_last = 0;
    beat_reg = 0; beat_base = 0; beat_off = 0; mem_ack = 0; mem_rdata = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_beat_ready", beat_ready, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rf_wr_en", rf_wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    #1 chk("post_rst_beat_ready", beat_ready, 1);
    @(negedge clk);

    // LM reg3 @ 0x0100+2, ack on first ISSUE cycle (ack already high in IDLE is ignored)
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    send(1, 0, 3'd3, 16'h0100, 16'h0002, 1);
    chk("lm_c1_mem_req", mem_req, 1);
    chk("lm_c1_mem_addr", mem_addr, 16'h0102);
    chk("lm_c1_mem_we", mem_we, 0);
    chk("lm_c1_wdata", mem_wdata, 0);
    chk("lm_c1_ready", beat_ready, 0);
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 16'h0;
    chk("lm_c2_wr_en", rf_wr_en, 1);
    chk("lm_c2_wr_addr", rf_wr_addr, 3);
    chk("lm_c2_wr_data", rf_wr_data, 16'hBEEF);
    chk("lm_c2_mem_req", mem_req, 0);
    @(negedge clk);
    chk("lm_c3_done", done, 1);
    chk("lm_c3_wr_en", rf_wr_en, 0);
    @(negedge clk);
    chk("lm_c4_done", done, 0);
    chk("lm_c4_ready", beat_ready, 1);

    // SM reg5, address wrap, ack in the fifth ISSUE cycle
    send(0, 1, 3'd5, 16'hFFFF, 16'h0001, 1);
    for (int c = 1; c <= 5; c++) begin
      chk("sm_mem_req", mem_req, 1);
      chk("sm_mem_addr", mem_addr, 16'h0000);
      chk("sm_mem_we", mem_we, 1);
      chk("sm_wdata", mem_wdata, 16'h1234);
      chk("sm_rd_addr", rf_rd_addr, 5);
      chk("sm_no_wr", rf_wr_en, 0);
      chk("sm_err", err, 0);
      if (c == 5) mem_ack = 1'b1;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    chk("sm_done", done, 1);
    chk("sm_done_mem_req", mem_req, 0);
    chk("sm_done_wr_en", rf_wr_en, 0);
    @(negedge clk);
    chk("sm_wr_cnt", wr_cnt, 1);

    // Three LM beats, regs 0/2/7, offsets 0/1/2 from 0x0200
    for (int i = 0; i < 3; i++) begin
      logic [2:0] r;
      r = (i == 0) ? 3'd0 : (i == 1) ? 3'd2 : 3'd7;
      send(1, 0, r, 16'h0200, 16'(i), i == 2);
      chk("lm3_mem_addr", mem_addr, 16'h0200 + i);
      mem_ack = 1'b1; mem_rdata = 16'hA000 + 16'(i);
      @(negedge clk);
      mem_ack = 1'b0;
      chk("lm3_wr_en", rf_wr_en, 1);
      chk("lm3_wr_addr", rf_wr_addr, r);
      chk("lm3_wr_data", rf_wr_data, 16'hA000 + i);
      @(negedge clk);
      chk("lm3_done", done, i == 2);
      if (i == 2) @(negedge clk);
    end
    chk("lm3_done_cnt", done_cnt, 3);
    chk("lm3_wr_cnt", wr_cnt, 4);

    // Malformed beats: both kinds, then neither
    send(1, 1, 3'd1, 16'h0300, 16'h0000, 1);
    chk("both_mem_req", mem_req, 0);
    chk("both_ready", beat_ready, 1);
    send(0, 0, 3'd1, 16'h0300, 16'h0000, 1);
    chk("none_mem_req", mem_req, 0);
    @(negedge clk);
    chk("none_done", done, 0);
    chk("none_wr_cnt", wr_cnt, 4);

    // Reset while in ISSUE
    send(0, 1, 3'd5, 16'h0400, 16'h0000, 1);
    chk("mid_rst_pre_req", mem_req, 1);
    #2 rst = 1'b1;
    #1 chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_ready", beat_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    mem_ack = 1'b0;
    chk("mid_rst_ready_after", beat_ready, 1);
    chk("mid_rst_done_cnt", done_cnt, 3);
    chk("mid_rst_wr_cnt", wr_cnt, 4);

`ifdef LM_SM_TIMEOUT_EN
    // No ack: err in the 16th ISSUE cycle, then back to IDLE
    send(1, 0, 3'd4, 16'h0500, 16'h0000, 1);
    for (int c = 1; c <= 16; c++) begin
      chk("to_mem_req", mem_req, 1);
      chk("to_err", err, c == 16);
      @(negedge clk);
    end
    chk("to_err_after", err, 0);
    chk("to_ready", beat_ready, 1);
    chk("to_mem_req_after", mem_req, 0);
    @(negedge clk);
    chk("to_done_cnt", done_cnt, 3);
    chk("to_wr_cnt", wr_cnt, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
